// File: rtl/banco_pkg.sv
// banco_pkg: shared widths, reader FSM states and output beat type for the banco_registro read streamer.
package banco_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 6;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} lector_state_t;
    typedef struct packed {
        logic [2*DATA_W-1:0] data;
        logic [1:0]          keep;
        logic                last;
    } beat_t;
endpackage

// File: rtl/lector_banco_registro_salida_reg.sv
// lector_salida_reg: output beat register with valid/ready hold; LECTOR_PARIDAD_EN adds a registered per-word parity.
module lector_salida_reg
    import banco_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  out_ready,
    input  beat_t beat,
`ifdef LECTOR_PARIDAD_EN
    output logic [1:0] out_par,
`endif
    output logic  out_valid,
    output beat_t out_beat
);
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_beat  <= beat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`ifdef LECTOR_PARIDAD_EN
    // rs2 half is already zeroed for a single-word beat, so its parity is 0 there
    always_ff @(posedge clk) begin
        if (rst) out_par <= '0;
        else if (load) out_par <= {^beat.data[2*DATA_W-1:DATA_W], ^beat.data[DATA_W-1:0]};
    end
`endif
endmodule

// File: rtl/lector_banco_registro.sv
// lector_banco_registro: streams a contiguous banco_registro range two registers per beat; LECTOR_PARIDAD_EN adds out_par.
module lector_banco_registro
    import banco_pkg::*;
#(
    parameter int N = ADDR_W,
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] base_addr,
    input  logic [N:0]   count,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] addr_rs1,
    output logic [N-1:0] addr_rs2,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
`ifdef LECTOR_PARIDAD_EN
    output logic [1:0]   out_par,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2*W-1:0] out_data,
    output logic [1:0]   out_keep,
    output logic         out_last
);
    lector_state_t state, state_n;
    logic [N-1:0] ptr, ptr_n;
    logic [N:0]   rem, rem_n;
    logic         load;
    beat_t        beat, ob;

    assign addr_rs1 = ptr;
    assign addr_rs2 = ptr + N'(1);
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign load = state == STREAM && (!out_valid || out_ready) && rem != '0;
    assign beat.data = rem == (N+1)'(1) ? {{W{1'b0}}, rs1} : {rs2, rs1};
    assign beat.keep = rem == (N+1)'(1) ? 2'b01 : 2'b11;
    assign beat.last = rem <= (N+1)'(2);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rem_n   = rem;
        case (state)
            IDLE: if (start) begin
                state_n = count == '0 ? DONE : STREAM;
                ptr_n   = count == '0 ? ptr : base_addr;
                rem_n   = count;
            end
            STREAM: if (load) begin
                ptr_n   = ptr + N'(2);
                rem_n   = rem >= (N+1)'(2) ? rem - (N+1)'(2) : '0;
                state_n = rem <= (N+1)'(2) ? DRAIN : STREAM;
            end
            DRAIN: state_n = out_valid && out_ready ? DONE : DRAIN;
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            rem   <= rem_n;
        end
    end

    lector_salida_reg u_salida (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .out_ready (out_ready),
        .beat      (beat),
`ifdef LECTOR_PARIDAD_EN
        .out_par   (out_par),
`endif
        .out_valid (out_valid),
        .out_beat  (ob)
    );

    assign out_data = ob.data;
    assign out_keep = ob.keep;
    assign out_last = ob.last;
endmodule

// File: tb/tb_lector_banco_registro.sv
// tb_lector_banco_registro: directed bench with a behavioural bank where reg k holds (k+10) mod 64.
module tb_lector_banco_registro;
    logic        clk = 0;
    logic        rst, start, out_ready;
    logic [5:0]  base_addr;
    logic [6:0]  count;
    logic        busy, done, out_valid, out_last;
    logic [5:0]  addr_rs1, addr_rs2, rs1, rs2;
    logic [11:0] out_data;
    logic [1:0]  out_keep;
`ifdef LECTOR_PARIDAD_EN
    logic [1:0]  out_par;
`endif
    int tests = 0, fails = 0, hs = 0, hs0;

    always #5 clk = ~clk;

    function automatic logic [5:0] val(input int k);
        return 6'((k + 10) % 64);
    endfunction

    assign rs1 = val(int'(addr_rs1));
    assign rs2 = val(int'(addr_rs2));

    always @(posedge clk) if (out_valid && out_ready) hs <= hs + 1;

    lector_banco_registro dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .rs1(rs1), .rs2(rs2),
`ifdef LECTOR_PARIDAD_EN
        .out_par(out_par),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input int a, input logic [1:0] keep, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_data"}, 32'(out_data), keep[1] ? {val(a + 1), val(a)} : {6'd0, val(a)});
        chk({tag, "_keep"}, 32'(out_keep), 32'(keep));
        chk({tag, "_last"}, 32'(out_last), 32'(last));
    endtask

    task automatic go(input int b, input int c);
        base_addr = 6'(b);
        count = 7'(c);
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        rst = 1; start = 0; out_ready = 1; base_addr = 0; count = 0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr1", 32'(addr_rs1), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_keep", 32'(out_keep), 0);
        chk("rst_last", 32'(out_last), 0);
        rst = 0;
        tick();

        go(1, 4);
        chk("b1_busy", 32'(busy), 1);
        chk("b1_lat", 32'(out_valid), 0);
        tick(); beat("b1_0", 1, 2'b11, 0);
        tick(); beat("b1_1", 3, 2'b11, 1);
        tick();
        chk("b1_done", 32'(done), 1);
        chk("b1_vdrop", 32'(out_valid), 0);
        chk("b1_busyd", 32'(busy), 1);
        tick();
        chk("b1_done0", 32'(done), 0);
        chk("b1_busy0", 32'(busy), 0);

        go(2, 3);
        tick(); beat("b2_0", 2, 2'b11, 0);
        tick(); beat("b2_1", 4, 2'b01, 1);
        tick(); chk("b2_done", 32'(done), 1);
        tick();

        go(9, 0);
        chk("c0_busy", 32'(busy), 1);
        chk("c0_done", 32'(done), 1);
        chk("c0_valid", 32'(out_valid), 0);
        tick();
        chk("c0_busy0", 32'(busy), 0);
        chk("c0_done0", 32'(done), 0);
        chk("c0_valid0", 32'(out_valid), 0);

        go(62, 4);
        chk("w_addr1", 32'(addr_rs1), 62);
        chk("w_addr2", 32'(addr_rs2), 63);
        tick(); beat("w_0", 62, 2'b11, 0);
        chk("w_addr1b", 32'(addr_rs1), 0);
        chk("w_addr2b", 32'(addr_rs2), 1);
        tick(); beat("w_1", 64, 2'b11, 1);
        tick(); chk("w_done", 32'(done), 1);
        tick();

        hs0 = hs;
        go(0, 6);
        tick(); beat("bp_0", 0, 2'b11, 0);
        tick(); beat("bp_1", 2, 2'b11, 0);
        out_ready = 0;
        tick(); beat("bp_h1", 2, 2'b11, 0);
        chk("bp_ptr1", 32'(addr_rs1), 4);
        tick(); beat("bp_h2", 2, 2'b11, 0);
        chk("bp_ptr2", 32'(addr_rs1), 4);
        out_ready = 1;
        tick(); beat("bp_2", 4, 2'b11, 1);
        tick();
        chk("bp_done", 32'(done), 1);
        chk("bp_beats", 32'(hs - hs0), 3);
        tick();

        go(0, 6);
        tick(); beat("ra_0", 0, 2'b11, 0);
        rst = 1;
        tick();
        chk("ra_valid", 32'(out_valid), 0);
        chk("ra_busy", 32'(busy), 0);
        chk("ra_done", 32'(done), 0);
        rst = 0;
        tick();
        chk("ra_done2", 32'(done), 0);
        chk("ra_busy2", 32'(busy), 0);
        go(1, 2);
        tick(); beat("ra_n", 1, 2'b11, 1);
        tick(); chk("ra_ndone", 32'(done), 1);
        tick();

        go(5, 64);
        for (int i = 0; i < 32; i++) begin
            tick();
            beat("full", 5 + 2 * i, 2'b11, i == 31);
`ifdef LECTOR_PARIDAD_EN
            chk("full_par", 32'(out_par), {^val(6 + 2 * i), ^val(5 + 2 * i)});
`endif
        end
        tick(); chk("full_done", 32'(done), 1);
        tick(); chk("full_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
